// File: rtl/alu_rsv_station_pkg.sv
// Shared types for the ALU reservation station: renamed instruction packet,
// station entry layout and a reference ALU evaluation helper.
package alu_rsv_station_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned PREG_W    = 6;
   localparam int unsigned ROB_IDX_W = 4;

   typedef enum logic [3:0] {
      AluAdd,
      AluSub,
      AluAnd,
      AluOr,
      AluXor,
      AluSll,
      AluSrl,
      AluSra,
      AluSlt,
      AluSltu
   } alu_op_t;

   // Renamed ALU instruction; rsX_data is meaningful once the matching ready bit is set.
   typedef struct packed {
      alu_op_t               alu_op;
      logic                  uses_rs1;
      logic                  uses_rs2;
      logic                  use_imm;
      logic [PREG_W-1:0]     rs1_ps;
      logic [PREG_W-1:0]     rs2_ps;
      logic [PREG_W-1:0]     pd;
      logic [ROB_IDX_W-1:0]  rob_id;
      logic [XLEN-1:0]       imm;
      logic [XLEN-1:0]       rs1_data;
      logic [XLEN-1:0]       rs2_data;
   } instr_pkt;

   typedef struct packed {
      logic     valid;
      logic     rs1_rdy;
      logic     rs2_rdy;
      instr_pkt pkt;
   } rs_entry_t;

   // Combinational ALU result for a packet with resolved operands.
   function automatic logic [XLEN-1:0] alu_eval(instr_pkt p);
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] r;
      a = p.rs1_data;
      b = p.use_imm ? p.imm : p.rs2_data;
      case (p.alu_op)
         AluAdd:  r = a + b;
         AluSub:  r = a - b;
         AluAnd:  r = a & b;
         AluOr:   r = a | b;
         AluXor:  r = a ^ b;
         AluSll:  r = a << b[4:0];
         AluSrl:  r = a >> b[4:0];
         AluSra:  r = $signed(a) >>> b[4:0];
         AluSlt:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         AluSltu: r = {{(XLEN-1){1'b0}}, (a < b)};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_rsv_station_age_select.sv
// Age matrix plus oldest-ready picker, shared by the reservation stations.
// age[i][j] = 1 means entry i is older than entry j.
module rs_age_select #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             alloc,
   input  logic [IDX_W-1:0] alloc_idx,
   input  logic [DEPTH-1:0] entry_valid,
   input  logic [DEPTH-1:0] req,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx
);

   logic [DEPTH-1:0][DEPTH-1:0] age_q;
   logic [DEPTH-1:0][DEPTH-1:0] age_d;
   logic [DEPTH-1:0]            blocked;
   logic [DEPTH-1:0]            grant_oh;

   // New entry is younger than everything currently held.
   always_comb begin
      age_d = age_q;
      if (alloc) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            age_d[alloc_idx][i] = 1'b0;
            if ((IDX_W'(i) != alloc_idx) && entry_valid[i]) begin
               age_d[i][alloc_idx] = 1'b1;
            end
         end
      end
   end

   // Age matrix state; flush forgets all ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         age_q <= '0;
      end else if (flush) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end

   // A requester is blocked if any other requester is older; valid entries form a total order.
   always_comb begin
      blocked = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         for (int unsigned j = 0; j < DEPTH; j++) begin
            if ((i != j) && req[j] && age_q[j][i]) begin
               blocked[i] = 1'b1;
            end
         end
      end
      grant_oh = req & ~blocked;
   end

   // Encode the (one-hot) winner.
   always_comb begin
      grant_idx = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (grant_oh[i]) begin
            grant_idx = IDX_W'(i);
         end
      end
      grant_valid = |grant_oh;
   end

endmodule

// File: rtl/alu_rsv_station.sv
// ALU reservation station: holds renamed instructions until both operands
// arrive over the CDB, then moves the oldest ready one into the issue slot.
module alu_rsv_station
   import alu_rsv_station_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              disp_valid,
   input  instr_pkt          disp_pkt,
   input  logic              disp_rs1_rdy,
   input  logic              disp_rs2_rdy,
   output logic              disp_ready,
   input  logic              cdb_valid,
   input  logic [PREG_W-1:0] cdb_pd,
   input  logic [XLEN-1:0]   cdb_data,
   output logic              issue_valid,
   output instr_pkt          issue_pkt,
   input  logic              issue_ready
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rs_entry_t        entries_q [DEPTH];
   rs_entry_t        entries_d [DEPTH];
   rs_entry_t        disp_entry;
   logic [DEPTH-1:0] entry_valid;
   logic [DEPTH-1:0] entry_ready;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_valid;
   logic             disp_fire;
   logic             issue_adv;
   logic             issue_take;
   logic             cdb_wake;
   logic             rs1_hit;
   logic             rs2_hit;
   logic             issue_valid_q;
   instr_pkt         issue_pkt_q;

   // Tag 0 is the hardwired zero register and never broadcasts a wakeup.
   assign cdb_wake = cdb_valid & (cdb_pd != '0);

   // Per-entry status from registered state only.
   always_comb begin
      entry_valid = '0;
      entry_ready = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         entry_valid[i] = entries_q[i].valid;
         entry_ready[i] = entries_q[i].valid & entries_q[i].rs1_rdy & entries_q[i].rs2_rdy;
      end
   end

   // Lowest-index free entry.
   always_comb begin
      free_idx = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (!entries_q[i].valid) begin
            free_idx = IDX_W'(i);
         end
      end
   end

   assign disp_ready = ~&entry_valid;
   assign disp_fire  = disp_valid & disp_ready;
   assign issue_adv  = ~issue_valid_q | issue_ready;
   assign issue_take = issue_adv & grant_valid;

   assign rs1_hit = cdb_wake & disp_pkt.uses_rs1 & (cdb_pd == disp_pkt.rs1_ps);
   assign rs2_hit = cdb_wake & disp_pkt.uses_rs2 & (cdb_pd == disp_pkt.rs2_ps);

   // Incoming entry, with same-cycle CDB bypass into the operand fields.
   always_comb begin
      disp_entry         = '0;
      disp_entry.valid   = 1'b1;
      disp_entry.pkt     = disp_pkt;
      disp_entry.rs1_rdy = ~disp_pkt.uses_rs1 | (disp_pkt.rs1_ps == '0) | disp_rs1_rdy | rs1_hit;
      disp_entry.rs2_rdy = ~disp_pkt.uses_rs2 | (disp_pkt.rs2_ps == '0) | disp_rs2_rdy | rs2_hit;
      if (rs1_hit) begin
         disp_entry.pkt.rs1_data = cdb_data;
      end
      if (rs2_hit) begin
         disp_entry.pkt.rs2_data = cdb_data;
      end
   end

   // Next-state of the entry array: wakeup, free on issue, write on dispatch.
   always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         entries_d[i] = entries_q[i];
         if (entries_q[i].valid && cdb_wake) begin
            if (!entries_q[i].rs1_rdy && (cdb_pd == entries_q[i].pkt.rs1_ps)) begin
               entries_d[i].rs1_rdy      = 1'b1;
               entries_d[i].pkt.rs1_data = cdb_data;
            end
            if (!entries_q[i].rs2_rdy && (cdb_pd == entries_q[i].pkt.rs2_ps)) begin
               entries_d[i].rs2_rdy      = 1'b1;
               entries_d[i].pkt.rs2_data = cdb_data;
            end
         end
         if (issue_take && (grant_idx == IDX_W'(i))) begin
            entries_d[i].valid = 1'b0;
         end
         // Dispatch targets a free entry, so it never collides with the issuing one.
         if (disp_fire && (free_idx == IDX_W'(i))) begin
            entries_d[i] = disp_entry;
         end
      end
   end

   // Entry array state; flush only needs to drop the valid bits.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else if (flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_q[i].valid <= 1'b0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            entries_q[i] <= entries_d[i];
         end
      end
   end

   // Issue slot: advances when empty or drained, otherwise holds its packet.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issue_valid_q <= 1'b0;
         issue_pkt_q   <= '0;
      end else if (flush) begin
         issue_valid_q <= 1'b0;
      end else if (issue_adv) begin
         issue_valid_q <= grant_valid;
         if (grant_valid) begin
            issue_pkt_q <= entries_q[grant_idx].pkt;
         end
      end
   end

   assign issue_valid = issue_valid_q;
   assign issue_pkt   = issue_pkt_q;

   rs_age_select #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_age_select (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .alloc       (disp_fire),
      .alloc_idx   (free_idx),
      .entry_valid (entry_valid),
      .req         (entry_ready),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

endmodule

// File: tb/tb_alu_rsv_station.sv
// Bench for alu_rsv_station: queue-based reference model checked every cycle,
// plus hand-computed expectations for latency, wakeup, bypass and age order.
module tb_alu_rsv_station;
   import alu_rsv_station_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              disp_valid;
   instr_pkt          disp_pkt;
   logic              disp_rs1_rdy;
   logic              disp_rs2_rdy;
   logic              disp_ready;
   logic              cdb_valid;
   logic [PREG_W-1:0] cdb_pd;
   logic [XLEN-1:0]   cdb_data;
   logic              issue_valid;
   instr_pkt          issue_pkt;
   logic              issue_ready;

   alu_rsv_station #(
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .disp_valid   (disp_valid),
      .disp_pkt     (disp_pkt),
      .disp_rs1_rdy (disp_rs1_rdy),
      .disp_rs2_rdy (disp_rs2_rdy),
      .disp_ready   (disp_ready),
      .cdb_valid    (cdb_valid),
      .cdb_pd       (cdb_pd),
      .cdb_data     (cdb_data),
      .issue_valid  (issue_valid),
      .issue_pkt    (issue_pkt),
      .issue_ready  (issue_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: entries kept in dispatch order, so the front-most ready one is oldest.
   typedef struct {
      logic     r1;
      logic     r2;
      instr_pkt pkt;
   } m_ent_t;

   m_ent_t               mq[$];
   logic                 m_slot_v;
   instr_pkt             m_slot;
   logic [ROB_IDX_W-1:0] issue_log[$];
   int                   vectors;
   int                   miscompares;

   task automatic check_bit(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_pkt(input string name, input instr_pkt act, input instr_pkt exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against the model, advance the model with the current inputs, clock once.
   task automatic step();
      int     cand;
      int     occ;
      logic   adv;
      logic   wake;
      m_ent_t ne;
      check_bit("disp_ready", disp_ready, (mq.size() < int'(DEPTH)));
      check_bit("issue_valid", issue_valid, m_slot_v);
      if (m_slot_v) check_pkt("issue_pkt", issue_pkt, m_slot);
      if (issue_valid && issue_ready) issue_log.push_back(issue_pkt.rob_id);

      cand = -1;
      for (int i = 0; i < mq.size(); i++) begin
         if (cand < 0 && mq[i].r1 && mq[i].r2) cand = i;
      end
      occ  = mq.size();
      adv  = !m_slot_v || issue_ready;
      wake = cdb_valid && (cdb_pd != 0);

      ne.pkt = disp_pkt;
      ne.r1  = !disp_pkt.uses_rs1 || disp_pkt.rs1_ps == 0 || disp_rs1_rdy;
      ne.r2  = !disp_pkt.uses_rs2 || disp_pkt.rs2_ps == 0 || disp_rs2_rdy;
      if (wake && disp_pkt.uses_rs1 && cdb_pd == disp_pkt.rs1_ps) begin
         ne.r1 = 1'b1;
         ne.pkt.rs1_data = cdb_data;
      end
      if (wake && disp_pkt.uses_rs2 && cdb_pd == disp_pkt.rs2_ps) begin
         ne.r2 = 1'b1;
         ne.pkt.rs2_data = cdb_data;
      end

      for (int i = 0; i < mq.size(); i++) begin
         if (wake && !mq[i].r1 && cdb_pd == mq[i].pkt.rs1_ps) begin
            mq[i].r1 = 1'b1;
            mq[i].pkt.rs1_data = cdb_data;
         end
         if (wake && !mq[i].r2 && cdb_pd == mq[i].pkt.rs2_ps) begin
            mq[i].r2 = 1'b1;
            mq[i].pkt.rs2_data = cdb_data;
         end
      end
      if (adv) begin
         if (cand >= 0) begin
            m_slot   = mq[cand].pkt;
            m_slot_v = 1'b1;
            mq.delete(cand);
         end else begin
            m_slot_v = 1'b0;
         end
      end
      if (disp_valid && occ < int'(DEPTH)) mq.push_back(ne);
      if (flush) begin
         mq.delete();
         m_slot_v = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic instr_pkt mk(input alu_op_t op, input logic [PREG_W-1:0] p1,
                                   input logic [PREG_W-1:0] p2, input logic [ROB_IDX_W-1:0] rob,
                                   input logic [31:0] d1, input logic [31:0] d2);
      instr_pkt p;
      p          = '0;
      p.alu_op   = op;
      p.uses_rs1 = 1'b1;
      p.uses_rs2 = 1'b1;
      p.rs1_ps   = p1;
      p.rs2_ps   = p2;
      p.pd       = PREG_W'(40) + PREG_W'(rob);
      p.rob_id   = rob;
      p.rs1_data = d1;
      p.rs2_data = d2;
      return p;
   endfunction

   task automatic idle();
      disp_valid   = 1'b0;
      disp_pkt     = '0;
      disp_rs1_rdy = 1'b0;
      disp_rs2_rdy = 1'b0;
      cdb_valid    = 1'b0;
      cdb_pd       = '0;
      cdb_data     = '0;
      flush        = 1'b0;
   endtask

   task automatic disp(input instr_pkt p, input logic r1, input logic r2);
      disp_valid   = 1'b1;
      disp_pkt     = p;
      disp_rs1_rdy = r1;
      disp_rs2_rdy = r2;
   endtask

   task automatic cdb(input logic [PREG_W-1:0] pd, input logic [31:0] d);
      cdb_valid = 1'b1;
      cdb_pd    = pd;
      cdb_data  = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [ROB_IDX_W-1:0] exp_order [5];
      exp_order = '{4'd9, 4'd11, 4'd12, 4'd10, 4'd13};
      vectors     = 0;
      miscompares = 0;
      m_slot_v    = 1'b0;
      m_slot      = '0;
      issue_ready = 1'b1;
      rst         = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      step();

      // 1: reset mid-run, then fill to full
      disp(mk(AluAdd, 6'd1, 6'd2, 4'd1, 32'd5, 32'd7), 1'b1, 1'b1);
      step();
      disp(mk(AluAdd, 6'd20, 6'd2, 4'd2, 32'd0, 32'd1), 1'b0, 1'b1);
      issue_ready = 1'b0;
      step();
      idle();
      step();
      #2;
      rst = 1'b0;
      #1;
      check_bit("t1_async_issue_valid", issue_valid, 1'b0);
      check_bit("t1_async_disp_ready", disp_ready, 1'b1);
      mq.delete();
      m_slot_v = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      issue_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         disp(mk(AluOr, PREG_W'(20 + k), 6'd2, ROB_IDX_W'(k), 32'd0, 32'd3), 1'b0, 1'b1);
         step();
      end
      disp(mk(AluOr, 6'd1, 6'd2, 4'd4, 32'd1, 32'd3), 1'b1, 1'b1);
      check_bit("t1_full_disp_ready", disp_ready, 1'b0);
      step();
      idle();
      flush = 1'b1;
      step();
      idle();
      check_bit("t1_flush_disp_ready", disp_ready, 1'b1);
      step();

      // 2: ready ADD issues two cycles after dispatch
      disp(mk(AluAdd, 6'd1, 6'd2, 4'd3, 32'd5, 32'd7), 1'b1, 1'b1);
      step();
      idle();
      check_bit("t2_n1_issue_valid", issue_valid, 1'b0);
      step();
      check_bit("t2_n2_issue_valid", issue_valid, 1'b1);
      check_word("t2_alu_result", alu_eval(issue_pkt), 32'd12);
      step();

      // 3: wakeup via CDB; tag 0 broadcast must not wake
      disp(mk(AluAdd, 6'd9, 6'd2, 4'd4, 32'd0, 32'd3), 1'b0, 1'b1);
      step();
      idle();
      cdb(6'd0, 32'h55);
      step();
      idle();
      step();
      cdb(6'd9, 32'h10);
      step();
      idle();
      check_bit("t3_n4_issue_valid", issue_valid, 1'b0);
      step();
      check_bit("t3_n5_issue_valid", issue_valid, 1'b1);
      check_word("t3_rs1_data", issue_pkt.rs1_data, 32'h10);
      step();

      // 4: same-cycle bypass at dispatch
      disp(mk(AluSub, 6'd1, 6'd9, 4'd5, 32'd1, 32'd0), 1'b1, 1'b0);
      cdb(6'd9, 32'h99);
      step();
      idle();
      step();
      check_bit("t4_n2_issue_valid", issue_valid, 1'b1);
      check_word("t4_rs2_data", issue_pkt.rs2_data, 32'h99);
      step();

      // 5: age order, a late-woken older entry beats a younger ready one
      issue_log.delete();
      disp(mk(AluAdd, 6'd1, 6'd2, 4'd9, 32'd1, 32'd1), 1'b1, 1'b1);
      step();
      disp(mk(AluAdd, 6'd30, 6'd2, 4'd10, 32'd0, 32'd2), 1'b0, 1'b1);
      step();
      issue_ready = 1'b0;
      disp(mk(AluXor, 6'd1, 6'd2, 4'd11, 32'd3, 32'd4), 1'b1, 1'b1);
      step();
      disp(mk(AluAnd, 6'd1, 6'd2, 4'd12, 32'd5, 32'd6), 1'b1, 1'b1);
      step();
      idle();
      step();
      issue_ready = 1'b1;
      step();
      step();
      cdb(6'd30, 32'h30);
      disp(mk(AluSlt, 6'd1, 6'd2, 4'd13, 32'd7, 32'd8), 1'b1, 1'b1);
      step();
      idle();
      for (int k = 0; k < 4; k++) step();
      check_word("t5_issue_count", 32'(issue_log.size()), 32'd5);
      for (int i = 0; i < issue_log.size() && i < 5; i++) begin
         check_word("t5_order", 32'(issue_log[i]), 32'(exp_order[i]));
      end

      // 6: backpressure holds the slot while the RS fills, then flush
      disp(mk(AluAdd, 6'd1, 6'd2, 4'd1, 32'd2, 32'd2), 1'b1, 1'b1);
      step();
      idle();
      step();
      issue_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_word("t6_hold_rob", 32'(issue_pkt.rob_id), 32'd1);
         disp(mk(AluAdd, 6'd1, 6'd2, ROB_IDX_W'(2 + k), 32'(k), 32'd1), 1'b1, 1'b1);
         step();
      end
      disp(mk(AluAdd, 6'd1, 6'd2, 4'd6, 32'd9, 32'd9), 1'b1, 1'b1);
      check_bit("t6_full_disp_ready", disp_ready, 1'b0);
      step();
      idle();
      issue_ready = 1'b1;
      flush = 1'b1;
      step();
      idle();
      check_bit("t6_flush_issue_valid", issue_valid, 1'b0);
      check_bit("t6_flush_disp_ready", disp_ready, 1'b1);
      step();
      // Flush wins over a dispatch in the same cycle.
      disp(mk(AluAdd, 6'd1, 6'd2, 4'd7, 32'd1, 32'd1), 1'b1, 1'b1);
      flush = 1'b1;
      step();
      idle();
      step();
      check_bit("t6_flush_drops_disp", issue_valid, 1'b0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
